// File: rtl/load_store_unit.sv
// Multi-cycle load/store engine between execute and a word-wide req/ack bus.
// Checks alignment, builds byte enables, replicates store data, extends loads.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [2:0]  mem_width,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  input  logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  off;
  logic [2:0]  width;

  logic        illegal;
  logic        misal;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] sh;
  logic [31:0] ext;

  // Decode the incoming request: legality, alignment, lanes, write data.
  always_comb begin
    illegal = (mem_width == 3'b011) ||
              (mem_width[2:1] == 2'b11) ||
              (mem_width[2] && is_store);
    misal = ((mem_width[1:0] == 2'b01) && addr[0]) ||
            ((mem_width[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    be    = 4'b1111;
    wdata = store_data;
    case (mem_width[1:0])
      2'b00: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {addr[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    sh  = bus_rdata >> {off, 3'b000};
    ext = sh;
    case (width)
      3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ext = {24'd0, sh[7:0]};
      3'b101:  ext = {16'd0, sh[15:0]};
      default: ext = sh;
    endcase
  end

  // Transaction FSM with registered bus and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      off        <= '0;
      width      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_data  <= '0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
            off        <= addr[1:0];
            width      <= mem_width;
            busy       <= 1'b1;
            cnt        <= '0;
            if (illegal) begin
              bus_error <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else if (misal) begin
              misaligned <= 1'b1;
              done       <= 1'b1;
              state      <= DONE;
            end else begin
              bus_addr  <= {addr[31:2], 2'b00};
              bus_we    <= is_store;
              bus_be    <= be;
              bus_wdata <= wdata;
              bus_req   <= 1'b1;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 16'd1;
          if (bus_err) begin
            bus_error <= 1'b1;
            bus_req   <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (bus_ack) begin
            if (!bus_we) load_data <= ext;
            bus_req <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            bus_error <= 1'b1;
            bus_req   <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: results checked by a done monitor,
// bus beats checked by a responding slave model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [2:0]  mem_width;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_error;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .addr(addr), .store_data(store_data), .mem_width(mem_width),
    .busy(busy), .done(done), .load_data(load_data),
    .misaligned(misaligned), .bus_error(bus_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    logic        err;
  } res_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  res_t  res_q[$];
  beat_t bus_q[$];

  int total = 0;
  int bad   = 0;

  // slave configuration: mode 0 = ack, 1 = err, 2 = never respond
  int          s_waits = 0;
  int          s_mode  = 0;
  int          s_cyc   = 0;
  int          req_len = 0;
  beat_t       cur;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus slave: checks each beat against the queue, holds it stable, responds.
  always @(negedge clk) begin
    if (bus_req && !reset) begin
      if (s_cyc == 0) begin
        if (bus_q.size() == 0) begin
          chk("unexpected_bus_req", 32'd1, 32'd0);
          cur = '{bus_addr, bus_we, bus_be, bus_wdata};
        end else begin
          cur = bus_q.pop_front();
          chk("bus_addr", bus_addr, cur.addr);
          chk("bus_we", 32'(bus_we), 32'(cur.we));
          chk("bus_be", 32'(bus_be), 32'(cur.be));
          chk("bus_wdata", bus_wdata, cur.wdata);
        end
      end else begin
        chk("bus_stable", {bus_addr[31:2], bus_we, bus_be[0]},
            {cur.addr[31:2], cur.we, cur.be[0]});
        chk("wdata_stable", bus_wdata, cur.wdata);
      end
      bus_ack = (s_cyc == s_waits) && (s_mode == 0);
      bus_err = (s_cyc == s_waits) && (s_mode == 1);
      s_cyc++;
      req_len = s_cyc;
    end else begin
      bus_ack = 1'b0;
      bus_err = 1'b0;
      s_cyc   = 0;
    end
  end

  // Result monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (res_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        res_t r;
        r = res_q.pop_front();
        chk("load_data", load_data, r.ld);
        chk("misaligned", 32'(misaligned), 32'(r.mis));
        chk("bus_error", 32'(bus_error), 32'(r.err));
      end
    end
  end

  task automatic op(input logic st, input logic [31:0] a,
                    input logic [31:0] sd, input logic [2:0] w,
                    input int waits, input int mode,
                    input logic [31:0] rd,
                    input logic [3:0] ebe, input logic [31:0] ewd,
                    input logic [31:0] eld, input logic emis,
                    input logic eerr, input int elat, input int ereq);
    int lat;
    int bcnt;
    bit seen;
    res_q.push_back('{eld, emis, eerr});
    if (ereq > 0) bus_q.push_back('{{a[31:2], 2'b00}, st, ebe, ewd});
    @(negedge clk);
    s_waits    = waits;
    s_mode     = mode;
    bus_rdata  = rd;
    req_len    = 0;
    is_store   = st;
    addr       = a;
    store_data = sd;
    mem_width  = w;
    start      = 1'b1;
    lat  = 0;
    bcnt = 0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) bcnt++;
      if (done) seen = 1;
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    chk("latency", 32'(lat), 32'(elat));
    chk("busy_cycles", 32'(bcnt), 32'(elat));
    chk("req_cycles", 32'(req_len), 32'(ereq));
    @(negedge clk);
    chk("done_pulse_end", {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; addr = '0;
    store_data = '0; mem_width = '0; bus_rdata = '0;
    bus_ack = 1'b0; bus_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {26'd0, busy, done, misaligned, bus_error,
        bus_req, bus_we}, 32'd0);
    chk("reset_ld", load_data, 32'd0);
    chk("reset_bus", bus_addr | bus_wdata | 32'(bus_be), 32'd0);
    reset = 1'b0;

    // LB, byte 3, ack on first req cycle
    op(0, 32'h1003, 0, 3'b000, 0, 0, 32'h8000_0000,
       4'b1000, 32'h0, 32'hFFFF_FF80, 0, 0, 2, 1);
    // LHU upper half, 3 wait cycles
    op(0, 32'h2002, 0, 3'b101, 3, 0, 32'hBEEF_1234,
       4'b1100, 32'h0, 32'h0000_BEEF, 0, 0, 5, 4);
    // SB lane 1, 2 wait cycles
    op(1, 32'h3001, 32'h1234_56AB, 3'b000, 2, 0, 32'h0,
       4'b0010, 32'hABAB_ABAB, 32'h0000_BEEF, 0, 0, 4, 3);
    // LW misaligned
    op(0, 32'h4002, 0, 3'b010, 0, 0, 32'h0,
       4'b0, 32'h0, 32'h0000_BEEF, 1, 0, 1, 0);
    // SW clears misaligned
    op(1, 32'h4004, 32'hCAFE_F00D, 3'b010, 0, 0, 32'h0,
       4'b1111, 32'hCAFE_F00D, 32'h0000_BEEF, 0, 0, 2, 1);
    // LW with silent bus: timeout after 4 req cycles
    op(0, 32'h5000, 0, 3'b010, 0, 2, 32'h0,
       4'b1111, 32'h0, 32'h0000_BEEF, 0, 1, 5, 4);
    // SW with unsigned width is illegal
    op(1, 32'h5004, 32'h1, 3'b100, 0, 0, 32'h0,
       4'b0, 32'h0, 32'h0000_BEEF, 0, 1, 1, 0);
    // LH lower half, negative
    op(0, 32'h6000, 0, 3'b001, 1, 0, 32'h0001_8765,
       4'b0011, 32'h0, 32'hFFFF_8765, 0, 0, 3, 2);
    // SH upper half replicates
    op(1, 32'h6102, 32'hAAAA_5A5A, 3'b001, 0, 0, 32'h0,
       4'b1100, 32'h5A5A_5A5A, 32'hFFFF_8765, 0, 0, 2, 1);
    // LBU lane 1
    op(0, 32'h7001, 0, 3'b100, 0, 0, 32'h0000_F200,
       4'b0010, 32'h0, 32'h0000_00F2, 0, 0, 2, 1);
    // bus_err response after one wait
    op(0, 32'h8000, 0, 3'b010, 1, 1, 32'h1234_5678,
       4'b1111, 32'h0, 32'h0000_00F2, 0, 1, 3, 2);
    // illegal width 011 on load
    op(0, 32'h8000, 0, 3'b011, 0, 0, 32'h0,
       4'b0, 32'h0, 32'h0000_00F2, 0, 1, 1, 0);
    // LHU misaligned
    op(0, 32'h8001, 0, 3'b101, 0, 0, 32'h0,
       4'b0, 32'h0, 32'h0000_00F2, 1, 0, 1, 0);

    // reset while waiting in REQ
    bus_q.push_back('{32'h9000, 1'b0, 4'b1111, 32'h0});
    @(negedge clk);
    s_mode = 2; is_store = 0; addr = 32'h9000;
    mem_width = 3'b010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("req_before_reset", 32'(bus_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid", {29'd0, bus_req, busy, done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", {29'd0, bus_req, busy, done}, 32'd0);

    // normal LW after the abandoned request
    op(0, 32'h9000, 0, 3'b010, 0, 0, 32'h1122_3344,
       4'b1111, 32'h0, 32'h1122_3344, 0, 0, 2, 1);

    repeat (3) @(negedge clk);
    chk("res_q_empty", 32'(res_q.size()), 32'd0);
    chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle load/store engine placed between the execute datapath (ALU address, rs2 store data, funct3 width) and a word-wide data bus with a req/ack handshake. It replaces the single-cycle data memory access path and stalls the core while a transaction is in flight. It performs alignment checking, byte-enable generation, store-data lane replication, and load-data sign/zero extension.

Parameters:
TIMEOUT_CYCLES, 255, number of REQ cycles without ack/err before bus_error is raised (1..65535).

Ports:
clk  input  1  system clock, all state on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request strobe; sampled only in IDLE.
is_store  input  1  1 = store, 0 = load; sampled with start.
addr  input  32  byte address from ALU.
store_data  input  32  rs2 value.
mem_width  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
busy  output  1  high in every non-IDLE state; drives core stall.
done  output  1  one-cycle completion pulse (success or error).
load_data  output  32  extended load result; valid when done is high after a load.
misaligned  output  1  alignment fault flag for the last accepted request.
bus_error  output  1  bus error/timeout/illegal-width flag for the last accepted request.
bus_req  output  1  bus request, held until ack/err.
bus_we  output  1  bus write enable.
bus_addr  output  32  word address ({addr[31:2],2'b00}).
bus_be  output  4  byte lane enables.
bus_wdata  output  32  lane-replicated store data.
bus_rdata  input  32  read data, valid with bus_ack.
bus_ack  input  1  transfer complete.
bus_err  input  1  transfer failed (takes priority over bus_ack).

Behaviour:
- Reset: state IDLE. All outputs 0: busy, done, load_data, misaligned, bus_error, bus_req, bus_we, bus_addr, bus_be, bus_wdata. Timeout counter 0.
- Ports are clk and reset. One clock. Reset is synchronous and active-high.
- States: IDLE, REQ, DONE.
- IDLE with start=1: clear both flags and latch the request.
  - Illegal width (011, 11x, or 1xx with is_store=1): set bus_error, go to DONE with no bus access.
  - Misaligned (H with addr[0]=1; W with addr[1:0]!=0): set misaligned, go to DONE with no bus access.
  - Otherwise register bus_addr, bus_we=is_store, bus_be and bus_wdata, set bus_req=1, go to REQ.
- Byte enables:
  - B/BU: 4'b0001<<addr[1:0].
  - H/HU: 4'b0011<<{addr[1],1'b0}.
  - W: 4'b1111.
- bus_wdata: B = {4{store_data[7:0]}}; H = {2{store_data[15:0]}}; W = store_data.
- REQ:
  - bus_req, bus_addr, bus_we, bus_be and bus_wdata stay stable.
  - Timeout counter increments each cycle.
  - bus_err=1: set bus_error, go to DONE.
  - Else bus_ack=1: for loads, extract the lane selected by addr[1:0] and sign-extend (B, H) or zero-extend (BU, HU) into load_data. Go to DONE.
  - Else counter==TIMEOUT_CYCLES-1: set bus_error, go to DONE.
  - bus_req drops on the edge leaving REQ.
- DONE: done=1 for exactly one cycle, busy=1. Return to IDLE; counter cleared.
- Latency: start accepted at edge 0 gives bus_req=1 at edge 0+. Ack sampled at edge k (k>=1) gives done high for the cycle after edge k. With a zero-wait bus, done is high 2 cycles after start. Fault paths give done 1 cycle after start.
- start outside IDLE is ignored and not queued.
- Holding and clearing rules:
  - load_data holds until the next successful load.
  - misaligned and bus_error hold until the next accepted start.
  - load_data is unchanged on stores and faults.
- Reset mid-transaction: the next edge returns to IDLE with bus_req=0 and no done pulse. The bus slave must tolerate an abandoned request.
- No back-to-back overlap: the earliest next start is accepted in the IDLE cycle after DONE.

Test Plan:
- LB addr=0x1003, bus_rdata=0x80_00_00_00, ack 1 cycle after req -> bus_be=1000, done 2 cycles after start, load_data=0xFFFFFF80, flags 0.
- LHU addr=0x2002, bus_rdata=0xBEEF1234, 3 wait cycles -> bus_be=1100, bus_addr=0x2000, load_data=0x0000BEEF, busy high 5 cycles.
- SB addr=0x3001, store_data=0x123456AB -> bus_we=1, bus_be=0010, bus_wdata=0xABABABAB held stable through 2 wait cycles.
- LW addr=0x4002 -> no bus_req, misaligned=1, done 1 cycle after start. Next valid SW clears misaligned.
- TIMEOUT_CYCLES=4 with no ack -> bus_req high 4 cycles, then bus_error=1, done pulse. Also: SW with mem_width=100 -> bus_error=1 with no bus_req.
- Reset asserted during REQ wait -> next cycle bus_req=0, busy=0, no done. A new LW then completes normally.
